// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths, funct3 codes, FSM states and helpers for div_unit
package div_unit_pkg;
  localparam int XLEN = 64;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(XLEN/2+1){1'b1}}, {(XLEN/2-1){1'b0}}};
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] x);
    return w ? {{(XLEN/2){x[XLEN/2-1]}}, x[XLEN/2-1:0]} : x;
  endfunction
endpackage

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W forms
module div_unit
  import div_unit_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  state_e          state_q;
  logic            busy_q, done_q, qneg_q, rneg_q, rem_op_q, word_q;
  logic [XLEN-1:0] result_q, dvd_q, dsr_q, quot_q;
  logic [XLEN:0]   rem_q;
  logic [5:0]      cnt_q;
  logic            sgn, rem_op, a_neg, b_neg, div_zero, ovf, ge;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, spec_d, fix_d, q_fix, r_fix, quot_d;
  logic [XLEN+1:0] trial, diff;
  logic [XLEN:0]   rem_d;
  // Operand preparation and special-case detection for the request on the inputs
  always_comb begin
    sgn      = funct3_i == F3_DIV || funct3_i == F3_REM;
    rem_op   = funct3_i == F3_REM || funct3_i == F3_REMU;
    a_ext    = word_i ? (sgn ? wfix(1'b1, dividend_i) : {32'b0, dividend_i[31:0]}) : dividend_i;
    b_ext    = word_i ? (sgn ? wfix(1'b1, divisor_i) : {32'b0, divisor_i[31:0]}) : divisor_i;
    a_neg    = sgn & a_ext[XLEN-1];
    b_neg    = sgn & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = b_ext == '0;
    ovf      = sgn && b_ext == '1 && a_ext == (word_i ? MIN_W : MIN_X);
    spec_d   = wfix(word_i, rem_op ? (div_zero ? a_ext : '0) : (div_zero ? '1 : a_ext));
  end
  // One restoring step: shift in the next dividend bit and keep the difference if non-negative
  always_comb begin
    trial  = {rem_q, dvd_q[XLEN-1]};
    diff   = trial - {2'b0, dsr_q};
    ge     = ~diff[XLEN+1];
    rem_d  = ge ? diff[XLEN:0] : trial[XLEN:0];
    quot_d = {quot_q[XLEN-2:0], ge};
  end
  // Sign fix-up and quotient/remainder selection
  always_comb begin
    q_fix = qneg_q ? -quot_q : quot_q;
    r_fix = rneg_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
    fix_d = wfix(word_q, rem_op_q ? r_fix : q_fix);
  end
  // Control FSM with datapath registers; kill aborts without touching the result
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      rem_op_q <= 1'b0;
      word_q   <= 1'b0;
    end else if (kill_i) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            dvd_q    <= word_i ? {a_mag[31:0], 32'b0} : a_mag;
            dsr_q    <= b_mag;
            quot_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= word_i ? 6'd31 : 6'd63;
            qneg_q   <= a_neg ^ b_neg;
            rneg_q   <= a_neg;
            rem_op_q <= rem_op;
            word_q   <= word_i;
            if (div_zero || ovf) begin
              state_q  <= S_DONE;
              done_q   <= 1'b1;
              result_q <= spec_d;
            end else begin
              state_q <= S_CALC;
              busy_q  <= 1'b1;
            end
          end
        end
        S_CALC: begin
          rem_q   <= rem_d;
          quot_q  <= quot_d;
          dvd_q   <= {dvd_q[XLEN-2:0], 1'b0};
          cnt_q   <= cnt_q - 6'd1;
          state_q <= cnt_q == '0 ? S_FIX : S_CALC;
        end
        S_FIX: begin
          result_q <= fix_d;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed scoreboard bench for div_unit with immediate-assertion checks
module tb_div_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic        word = 1'b0;
  logic [63:0] dividend = '0;
  logic [63:0] divisor = '0;
  logic        kill = 1'b0;
  logic        busy_o, done_o;
  logic [63:0] result_o;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];
  int          lat_q[$];

  div_unit dut (
    .clock(clock), .reset(reset), .start_i(start), .funct3_i(funct3), .word_i(word),
    .dividend_i(dividend), .divisor_i(divisor), .kill_i(kill),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    repeat (cycles) begin
      @(posedge clock); #1;
      if (done_o) n++;
    end
  endtask

  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input int exp_lat, input logic hold, input string tag);
    int edges;
    logic [63:0] er;
    int el;
    exp_q.push_back(exp_res);
    lat_q.push_back(exp_lat);
    @(negedge clock);
    funct3 = f3; word = w; dividend = a; divisor = b; start = 1'b1;
    @(posedge clock); #1;
    edges = 1;
    if (!hold) start = 1'b0;
    chk({tag, "_busy"}, {63'b0, busy_o}, {63'b0, exp_lat > 1});
    while (!done_o && edges < 200) begin
      @(posedge clock); #1;
      edges++;
    end
    start = 1'b0;
    er = exp_q.pop_front();
    el = lat_q.pop_front();
    chk({tag, "_done"}, {63'b0, done_o}, 64'd1);
    chk({tag, "_res"}, result_o, er);
    chk({tag, "_lat"}, 64'(edges), 64'(el));
    @(posedge clock); #1;
    chk({tag, "_pulse"}, {63'b0, done_o}, 64'd0);
  endtask

  task automatic abort_op(input logic use_reset, input int at, input logic [63:0] exp_res, input string tag);
    int n;
    @(negedge clock);
    funct3 = 3'b101; word = 1'b0; dividend = 64'd100; divisor = 64'd7; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (at - 2) @(posedge clock);
    #1;
    chk({tag, "_busy_pre"}, {63'b0, busy_o}, 64'd1);
    @(negedge clock);
    if (use_reset) reset = 1'b1; else kill = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; kill = 1'b0;
    chk({tag, "_busy_post"}, {63'b0, busy_o}, 64'd0);
    count_dones(80, n);
    chk({tag, "_no_done"}, 64'(n), 64'd0);
    chk({tag, "_res_kept"}, result_o, exp_res);
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", {63'b0, busy_o}, 64'd0);
    chk("rst_done", {63'b0, done_o}, 64'd0);
    chk("rst_res", result_o, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    run_op(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 66, 1'b0, "divu_100_7");
    run_op(3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 66, 1'b0, "remu_100_7");
    run_op(3'b100, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66, 1'b0, "div_m7_2");
    run_op(3'b110, 1'b0, -64'sd7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 1'b0, "rem_m7_2");
    run_op(3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0, "divu_by0");
    run_op(3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1, 1'b0, "remu_by0");
    run_op(3'b100, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, 1'b0, "div_ovf");
    run_op(3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1, 1'b0, "rem_ovf");
    run_op(3'b100, 1'b1, 64'h0000_0000_8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, 1'b0, "divw_ovf");
    run_op(3'b101, 1'b1, 64'h1_FFFF_FFFE, 64'd2, 64'h0000_0000_7FFF_FFFF, 34, 1'b0, "divuw");
    run_op(3'b110, 1'b1, -64'sd9, 64'd4, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b0, "remw_m9_4");
    run_op(3'b101, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34, 1'b0, "divuw_sext");
    run_op(3'b111, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'h10, 64'd15, 34, 1'b0, "remuw");
    run_op(3'b000, 1'b0, 64'd100, 64'd7, 64'd14, 66, 1'b0, "f3_other");
    run_op(3'b111, 1'b1, 64'd9, 64'd0, 64'd9, 1, 1'b0, "remuw_by0");
    abort_op(1'b0, 10, 64'd9, "kill");
    run_op(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 66, 1'b0, "after_kill");
    abort_op(1'b1, 20, 64'd0, "reset_mid");
    run_op(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 66, 1'b0, "after_reset");
    run_op(3'b100, 1'b0, 64'd100, -64'sd7, 64'hFFFF_FFFF_FFFF_FFF2, 66, 1'b1, "hold_start");
    count_dones(80, n);
    chk("hold_single_done", 64'(n), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
